imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 144 ++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length byte plus big-endian instruction bytes over
// valid/ready and writes them as 32-bit words from BaseAddr upward, holding the pipeline meanwhile.
module imem_loader #(
  parameter int unsigned BaseAddr = 100,
  parameter int unsigned MaxWords = 7
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  in_byte_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        hold_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  loaded_count_o
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StWrite, StDone, StErr} state_e;

  state_e      state_q;
  logic [7:0]  n_q;
  logic [7:0]  word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
  logic        in_ready_q;
  logic        imem_we_q;
  logic [31:0] imem_addr_q;
  logic [31:0] imem_wdata_q;
  logic        hold_q;
  logic        done_q;
  logic        error_q;
  logic [7:0]  count_q;

  logic        accept;
  logic [31:0] word_next;
  logic [31:0] addr_next;

  assign accept    = in_valid_i & in_ready_q;
  assign word_next = {word_q[23:0], in_byte_i};
  assign addr_next = 32'(BaseAddr) + {22'd0, word_idx_q, 2'b00};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      n_q          <= 8'd0;
      word_idx_q   <= 8'd0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'd0;
      imem_wdata_q <= 32'd0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      // Strobes are one-cycle; each state that wants them re-asserts on entry.
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StLen;
            in_ready_q <= 1'b1;
            hold_q     <= 1'b1;
            error_q    <= 1'b0;
            count_q    <= 8'd0;
          end
        end
        StLen: begin
          if (accept) begin
            if (in_byte_i == 8'd0) begin
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end else if (in_byte_i > 8'(MaxWords)) begin
              state_q    <= StErr;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q    <= StData;
              n_q        <= in_byte_i;
              byte_idx_q <= 2'd0;
              word_idx_q <= 8'd0;
            end
          end
        end
        StData: begin
          if (accept) begin
            word_q     <= word_next;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q      <= StWrite;
              in_ready_q   <= 1'b0;
              imem_we_q    <= 1'b1;
              imem_addr_q  <= addr_next;
              imem_wdata_q <= word_next;
            end
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_q + 8'd1;
          count_q    <= count_q + 8'd1;
          if (word_idx_q + 8'd1 == n_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q    <= StData;
            in_ready_q <= 1'b1;
            byte_idx_q <= 2'd0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          hold_q  <= 1'b0;
        end
        StErr: begin
          state_q <= StIdle;
          hold_q  <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
          hold_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign imem_we_o      = imem_we_q;
  assign imem_addr_o    = imem_addr_q;
  assign imem_wdata_o   = imem_wdata_q;
  assign hold_o         = hold_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign loaded_count_o = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader; expectations come from a word-list model
// of the load (addresses BaseAddr+4k, cycle 6+5k writes, done at 5N+2).
module tb_imem_loader;

  localparam int unsigned BaseAddr = 100;
  localparam int unsigned MaxWords = 7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        hold_o;
  logic        done_o;
  logic        error_o;
  logic [7:0]  loaded_count_o;

  imem_loader #(
    .BaseAddr(BaseAddr),
    .MaxWords(MaxWords)
  ) dut (
    .clock_i       (clk),
    .reset_i       (reset),
    .start_i       (start),
    .in_byte_i     (in_byte),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready_o),
    .imem_we_o     (imem_we_o),
    .imem_addr_o   (imem_addr_o),
    .imem_wdata_o  (imem_wdata_o),
    .hold_o        (hold_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .loaded_count_o(loaded_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] words [$];
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          wc [$];
  logic [31:0] mem [128];

  // Instruction memory as seen by the fetch path: every strobed write lands here.
  always @(negedge clk) begin
    if (!reset && imem_we_o) begin
      wa.push_back(imem_addr_o);
      wd.push_back(imem_wdata_o);
      wc.push_back(cyc);
      mem[imem_addr_o[6:0]] = imem_wdata_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready_o), 32'd0);
    chk({tag, ".we"}, 32'(imem_we_o), 32'd0);
    chk({tag, ".addr"}, imem_addr_o, 32'd0);
    chk({tag, ".wdata"}, imem_wdata_o, 32'd0);
    chk({tag, ".hold"}, 32'(hold_o), 32'd0);
    chk({tag, ".done"}, 32'(done_o), 32'd0);
    chk({tag, ".error"}, 32'(error_o), 32'd0);
    chk({tag, ".count"}, 32'(loaded_count_o), 32'd0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // mode 0: in_valid high, 1: toggling, 2: random. reset_at < 0 means no mid-load reset.
  task automatic run_load(input string tag, input int n, input int mode, input bit start_mid,
                          input int reset_at);
    logic [7:0] sb [$];
    bit legal;
    bit fin;
    bit v;
    bit acc;
    int done_cnt;
    int done_cyc;
    int hold_cnt;
    int nexp;
    legal = (n >= 1) && (n <= int'(MaxWords));
    sb.push_back(8'(n));
    if (legal) begin
      for (int k = 0; k < n; k++) begin
        for (int b = 3; b >= 0; b--) sb.push_back(8'(words[k] >> (8 * b)));
      end
    end
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
    done_cyc = -1;
    hold_cnt = 0;
    fin = 1'b0;
    start = 1'b1;
    in_valid = 1'b0;
    cyc = 0;
    tick();
    start = 1'b0;
    while (!fin && cyc < 400) begin
      if (hold_o) hold_cnt++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!hold_o) begin
        fin = 1'b1;
      end else begin
        reset = (cyc == reset_at);
        start = start_mid && (cyc == 3);
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2) == 0;
          default: v = 1'($urandom_range(0, 1));
        endcase
        v = v && (sb.size() > 0);
        in_valid = v;
        in_byte = v ? sb[0] : 8'($urandom);
        acc = v && in_ready_o && !reset;
        tick();
        if (acc) void'(sb.pop_front());
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
      end
    end
    chk({tag, ".terminated"}, 32'(fin), 32'd1);
    if (reset_at >= 0) begin
      chk({tag, ".rst_cycle"}, cyc, reset_at + 1);
      chk_reset_state({tag, ".rst"});
      chk({tag, ".rst_nwrites"}, wa.size(), 32'd1);
      chk({tag, ".rst_mem100"}, mem[BaseAddr], words[0]);
    end else begin
      nexp = legal ? n : 0;
      chk({tag, ".nwrites"}, wa.size(), nexp);
      for (int k = 0; k < nexp && k < wa.size(); k++) begin
        chk($sformatf("%s.addr%0d", tag, k), wa[k], BaseAddr + 4 * k);
        chk($sformatf("%s.data%0d", tag, k), wd[k], words[k]);
        if (mode == 0) chk($sformatf("%s.wcyc%0d", tag, k), wc[k], 6 + 5 * k);
      end
      chk({tag, ".done_cnt"}, done_cnt, (n > int'(MaxWords)) ? 0 : 1);
      if (mode == 0 && n <= int'(MaxWords)) begin
        chk({tag, ".done_cyc"}, done_cyc, (n == 0) ? 2 : 5 * n + 2);
      end
      if (mode == 0) chk({tag, ".hold_cycles"}, hold_cnt, legal ? 5 * n + 2 : 2);
      chk({tag, ".error"}, 32'(error_o), 32'(n > int'(MaxWords)));
      chk({tag, ".count"}, 32'(loaded_count_o), nexp);
      chk({tag, ".in_ready_idle"}, 32'(in_ready_o), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    tick();
    tick();
    chk_reset_state("reset");
    reset = 1'b0;
    tick();

    words.delete();
    words.push_back(32'h0022_1820);
    words.push_back(32'h0123_2022);
    run_load("two_words", 2, 0, 1'b0, -1);
    tick();
    run_load("two_toggle", 2, 1, 1'b0, -1);
    tick();
    run_load("len_zero", 0, 0, 1'b0, -1);
    tick();
    run_load("len_over", 8, 0, 1'b0, -1);
    tick();
    tick();
    chk("err_sticky", 32'(error_o), 32'd1);
    rand_words(3);
    run_load("after_err", 3, 2, 1'b0, -1);
    tick();

    words.delete();
    words.push_back(32'h0022_1820);
    words.push_back(32'h0123_2022);
    run_load("mid_reset", 2, 0, 1'b0, 9);
    tick();

    rand_words(5);
    run_load("start_in_data", 5, 0, 1'b1, -1);
    tick();
    rand_words(int'(MaxWords));
    run_load("max_random", int'(MaxWords), 2, 1'b0, -1);
    tick();
    rand_words(1);
    run_load("one_word", 1, 0, 1'b0, -1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
